motion_sequencer: RTL and testbench

Command scheduler placed in front of the motor control/pulse datapath. It queues motor move commands (motor index plus three-digit BCD target) from the host or keypad logic and presents them to the control block one at a time. Each command drives the one-hot `Motor` strobe and held BCD target digits, then waits for the pulse generator's `Busy` to assert and fall before it issues the next command. A Stop edge or loss of origin calibration flushes all pending commands.

---
 rtl/motion_sequencer_if.sv | 22 ++
 rtl/motion_sequencer.sv | 145 ++++++++++++++
 tb/tb_motion_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motion_sequencer_if.sv
// Command handshake between host/keypad logic and the motion sequencer.
// Host drives a move request, the sequencer answers with ready.
interface motion_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_motor;
  logic [3:0] cmd_t0;
  logic [3:0] cmd_t1;
  logic [3:0] cmd_t2;

  modport master (
    output cmd_valid, cmd_motor,
    output cmd_t0, cmd_t1, cmd_t2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_motor,
    input  cmd_t0, cmd_t1, cmd_t2,
    output cmd_ready
  );
endinterface

// File: rtl/motion_sequencer.sv
// Queues motor move commands and issues them one at a time to the
// control block, tracking pulse-generator Busy for completion.
module motion_sequencer #(
  parameter int DEPTH    = 8,
  parameter int HOLD     = 4,
  parameter int ACK_WAIT = 16
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [5:0]             initFlag,
  input  logic                   SS,
  input  logic                   Busy,
  motion_sequencer_if.slave      cmd,
  output logic [5:0]             Motor,
  output logic [3:0]             TValue0,
  output logic [3:0]             TValue1,
  output logic [3:0]             TValue2,
  output logic                   move_done,
  output logic                   cmd_err,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   seq_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam int CW = $clog2(ACK_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    HALT
  } state_t;

  typedef struct packed {
    logic [2:0] m;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [3:0] t2;
  } ent_t;

  state_t        state;
  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wr, rd;
  logic [HW-1:0] hcnt;
  logic [CW-1:0] acnt;
  logic          cal, full, empty;
  logic          accept, bad, push, pop, flush;

  assign cal   = &initFlag;
  assign full  = fifo_count == (AW+1)'(DEPTH);
  assign empty = fifo_count == '0;
  assign head  = mem[rd];

  assign cmd.cmd_ready = !full && state != HALT && !SS && cal;

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign bad    = cmd.cmd_motor > 3'd5
               || cmd.cmd_t0 > 4'd9
               || cmd.cmd_t1 > 4'd9
               || cmd.cmd_t2 > 4'd9;
  assign push   = accept && !bad;

  // IDLE is exempt so an uncalibrated machine simply waits
  assign flush = SS || (!cal && state != IDLE);
  assign pop   = state == IDLE && !empty && cal && !flush;

  assign seq_active = state != IDLE;

  always_ff @(posedge sysclk) begin
    if (push)
      mem[wr] <= {cmd.cmd_motor, cmd.cmd_t0,
                  cmd.cmd_t1, cmd.cmd_t2};
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr         <= '0;
      rd         <= '0;
      fifo_count <= '0;
      hcnt       <= '0;
      acnt       <= '0;
      Motor      <= '0;
      TValue0    <= '0;
      TValue1    <= '0;
      TValue2    <= '0;
      move_done  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      move_done <= 1'b0;
      cmd_err   <= accept && bad;
      if (flush) begin
        state      <= HALT;
        Motor      <= '0;
        fifo_count <= '0;
        rd         <= wr;
      end else begin
        if (push) wr <= wr + 1'b1;
        if (pop)  rd <= rd + 1'b1;
        unique case (1'b1)
          push && !pop: fifo_count <= fifo_count + 1'b1;
          pop && !push: fifo_count <= fifo_count - 1'b1;
          default: ;
        endcase
        case (state)
          IDLE: if (pop) begin
            state   <= ISSUE;
            Motor   <= 6'b1 << head.m;
            TValue0 <= head.t0;
            TValue1 <= head.t1;
            TValue2 <= head.t2;
            hcnt    <= '0;
          end
          ISSUE: if (hcnt == HW'(HOLD - 1)) begin
            state <= WAIT_ACK;
            Motor <= '0;
            acnt  <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
          // no Busy within the window means a zero-distance move
          WAIT_ACK: if (Busy) begin
            state <= WAIT_DONE;
          end else if (acnt == CW'(ACK_WAIT - 1)) begin
            state     <= IDLE;
            move_done <= 1'b1;
          end else begin
            acnt <= acnt + 1'b1;
          end
          WAIT_DONE: if (!Busy) begin
            state     <= IDLE;
            move_done <= 1'b1;
          end
          HALT: if (!Busy && cal)
            state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: reset, single move, reject,
// zero move, fill/drain with wrap, stop, calibration loss, reset.
module tb_motion_sequencer;

  logic       sysclk;
  logic       rst;
  logic [5:0] initFlag;
  logic       SS;
  logic       Busy;
  logic [5:0] Motor;
  logic [3:0] TValue0, TValue1, TValue2;
  logic       move_done, cmd_err, seq_active;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  motion_sequencer_if cif ();

  motion_sequencer #(
    .DEPTH(8), .HOLD(4), .ACK_WAIT(16)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .initFlag  (initFlag),
    .SS        (SS),
    .Busy      (Busy),
    .cmd       (cif),
    .Motor     (Motor),
    .TValue0   (TValue0),
    .TValue1   (TValue1),
    .TValue2   (TValue2),
    .move_done (move_done),
    .cmd_err   (cmd_err),
    .fifo_count(fifo_count),
    .seq_active(seq_active)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [2:0] m,
                       input logic [3:0] a, b, c);
    cif.cmd_motor = m;
    cif.cmd_t0    = a;
    cif.cmd_t1    = b;
    cif.cmd_t2    = c;
  endtask

  task automatic push(input logic [2:0] m,
                      input logic [3:0] a, b, c);
    drive(m, a, b, c);
    cif.cmd_valid = 1'b1;
    @(negedge sysclk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_motor(input bit on, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((Motor != 6'd0) == on) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge sysclk);
    checks++; if (Motor !== 6'd0) begin errors++; $display("FAIL reset_motor got %h exp 00", Motor); end
    checks++; if ({TValue0, TValue1, TValue2} !== 12'h000) begin errors++; $display("FAIL reset_tvalue got %h exp 000", {TValue0, TValue1, TValue2}); end
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", move_done); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cmd_err); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", seq_active); end
    checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cif.cmd_ready); end
    initFlag = 6'h1F;
    #1;
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_uncal got %b exp 0", cif.cmd_ready); end
    initFlag = 6'h3F;
    @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic test_single;
    int n;
    int md;
    push(3'd2, 4'd1, 4'd2, 4'd3);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", fifo_count); end
    checks++; if (Motor !== 6'd0) begin errors++; $display("FAIL single_motor_early got %h exp 00", Motor); end
    @(negedge sysclk);
    checks++; if (Motor !== 6'b000100) begin errors++; $display("FAIL single_motor got %b exp 000100", Motor); end
    checks++; if ({TValue0, TValue1, TValue2} !== 12'h123) begin errors++; $display("FAIL single_tvalue got %h exp 123", {TValue0, TValue1, TValue2}); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", fifo_count); end
    checks++; if (seq_active !== 1'b1) begin errors++; $display("FAIL single_active got %b exp 1", seq_active); end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (Motor == 6'd0) break;
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL single_hold got %0d exp 4", n); end
    repeat (2) @(negedge sysclk);
    Busy = 1'b1;
    md = 0;
    repeat (20) begin
      @(negedge sysclk);
      if (move_done) md++;
    end
    checks++; if (md != 0) begin errors++; $display("FAIL single_early_done got %0d exp 0", md); end
    checks++; if ({TValue0, TValue1, TValue2} !== 12'h123) begin errors++; $display("FAIL single_tvalue_held got %h exp 123", {TValue0, TValue1, TValue2}); end
    Busy = 1'b0;
    @(negedge sysclk);
    checks++; if (move_done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", move_done); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", seq_active); end
    @(negedge sysclk);
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", move_done); end
  endtask

  task automatic test_reject;
    push(3'd6, 4'd0, 4'd0, 4'd0);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL reject_motor_err got %b exp 1", cmd_err); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reject_motor_count got %0d exp 0", fifo_count); end
    @(negedge sysclk);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reject_err_pulse got %b exp 0", cmd_err); end
    push(3'd1, 4'd0, 4'hA, 4'd0);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL reject_digit_err got %b exp 1", cmd_err); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reject_digit_count got %0d exp 0", fifo_count); end
    @(negedge sysclk);
    checks++; if (Motor !== 6'd0) begin errors++; $display("FAIL reject_motor got %h exp 00", Motor); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL reject_active got %b exp 0", seq_active); end
  endtask

  task automatic test_zero;
    bit ok;
    int n;
    push(3'd3, 4'd9, 4'd9, 4'd9);
    @(negedge sysclk);
    checks++; if (Motor !== 6'b001000) begin errors++; $display("FAIL zero_motor got %b exp 001000", Motor); end
    wait_motor(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_strobe_end got timeout exp strobe end"); end
    n = 1;
    push(3'd4, 4'd0, 4'd0, 4'd1);
    n++;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL zero_queued got %0d exp 1", fifo_count); end
    while (n < 60 && !move_done) begin
      @(negedge sysclk);
      n++;
    end
    checks++; if (n != 17) begin errors++; $display("FAIL zero_done_delay got %0d exp 17", n); end
    checks++; if (Motor !== 6'd0) begin errors++; $display("FAIL zero_gap got %h exp 00", Motor); end
    @(negedge sysclk);
    checks++; if (Motor !== 6'b010000) begin errors++; $display("FAIL zero_next_motor got %b exp 010000", Motor); end
    checks++; if (TValue2 !== 4'd1) begin errors++; $display("FAIL zero_next_t2 got %0d exp 1", TValue2); end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysclk);
      if (move_done) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL zero_second_done got timeout exp pulse"); end
    @(negedge sysclk);
  endtask

  task automatic test_fill_drain;
    int dones;
    int idx;
    logic [5:0] prev;
    push(3'd5, 4'd0, 4'd0, 4'd0);
    @(negedge sysclk);
    Busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i % 6), 4'(i), 4'(9 - i), 4'd0);
      cif.cmd_valid = 1'b1;
      @(negedge sysclk);
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", fifo_count); end
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", cif.cmd_ready); end
    drive(3'd0, 4'd0, 4'd0, 4'd0);
    @(negedge sysclk);
    cif.cmd_valid = 1'b0;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_ninth got %0d exp 8", fifo_count); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL fill_ninth_err got %b exp 0", cmd_err); end
    Busy = 1'b0;
    dones = 0;
    idx = 0;
    prev = 6'd0;
    for (int c = 0; c < 600 && dones < 9; c++) begin
      @(negedge sysclk);
      if (move_done) dones++;
      if (Motor != 6'd0 && prev == 6'd0 && idx < 8) begin
        checks++; if (Motor !== (6'b1 << (idx % 6))) begin errors++; $display("FAIL drain_motor%0d got %b exp %b", idx, Motor, 6'b1 << (idx % 6)); end
        checks++; if ({TValue0, TValue1} !== {4'(idx), 4'(9 - idx)}) begin errors++; $display("FAIL drain_tvalue%0d got %h exp %h", idx, {TValue0, TValue1}, {4'(idx), 4'(9 - idx)}); end
        idx++;
      end
      prev = Motor;
    end
    checks++; if (idx != 8) begin errors++; $display("FAIL drain_issued got %0d exp 8", idx); end
    checks++; if (dones != 9) begin errors++; $display("FAIL drain_dones got %0d exp 9", dones); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", fifo_count); end
    @(negedge sysclk);
  endtask

  task automatic test_stop;
    int bad;
    push(3'd0, 4'd1, 4'd1, 4'd1);
    @(negedge sysclk);
    Busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'(i + 1), 4'd1, 4'd2, 4'd3);
      cif.cmd_valid = 1'b1;
      @(negedge sysclk);
    end
    cif.cmd_valid = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL stop_queued got %0d exp 3", fifo_count); end
    checks++; if (Motor !== 6'd0) begin errors++; $display("FAIL stop_wait_motor got %h exp 00", Motor); end
    SS = 1'b1;
    drive(3'd2, 4'd0, 4'd0, 4'd0);
    cif.cmd_valid = 1'b1;
    #1;
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_ready_ss got %b exp 0", cif.cmd_ready); end
    @(negedge sysclk);
    SS = 1'b0;
    cif.cmd_valid = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL stop_flush got %0d exp 0", fifo_count); end
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL stop_done got %b exp 0", move_done); end
    checks++; if (seq_active !== 1'b1 || cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_halt got active=%b ready=%b exp 1/0", seq_active, cif.cmd_ready); end
    bad = 0;
    repeat (5) begin
      @(negedge sysclk);
      if (move_done || Motor != 6'd0 || !seq_active) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stop_hold_halt got %0d exp 0", bad); end
    Busy = 1'b0;
    @(negedge sysclk);
    checks++; if (seq_active !== 1'b0 || cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL stop_exit got active=%b ready=%b exp 0/1", seq_active, cif.cmd_ready); end
    checks++; if (fifo_count !== 4'd0 || move_done !== 1'b0) begin errors++; $display("FAIL stop_after got count=%0d done=%b exp 0/0", fifo_count, move_done); end
  endtask

  task automatic test_uncal;
    initFlag = 6'h1F;
    #1;
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL uncal_ready got %b exp 0", cif.cmd_ready); end
    drive(3'd1, 4'd0, 4'd0, 4'd5);
    cif.cmd_valid = 1'b1;
    repeat (3) @(negedge sysclk);
    cif.cmd_valid = 1'b0;
    checks++; if (fifo_count !== 4'd0 || Motor !== 6'd0 || seq_active !== 1'b0) begin errors++; $display("FAIL uncal_idle got count=%0d motor=%h active=%b exp 0/00/0", fifo_count, Motor, seq_active); end
    initFlag = 6'h3F;
    push(3'd1, 4'd0, 4'd0, 4'd5);
    @(negedge sysclk);
    checks++; if (Motor !== 6'b000010) begin errors++; $display("FAIL uncal_issue got %b exp 000010", Motor); end
    initFlag = 6'h3E;
    @(negedge sysclk);
    checks++; if (Motor !== 6'd0 || seq_active !== 1'b1) begin errors++; $display("FAIL uncal_flush got motor=%h active=%b exp 00/1", Motor, seq_active); end
    checks++; if (TValue2 !== 4'd5) begin errors++; $display("FAIL uncal_tvalue got %0d exp 5", TValue2); end
    initFlag = 6'h3F;
    @(negedge sysclk);
    checks++; if (seq_active !== 1'b0 || move_done !== 1'b0) begin errors++; $display("FAIL uncal_exit got active=%b done=%b exp 0/0", seq_active, move_done); end
  endtask

  task automatic test_mid_reset;
    int bad;
    push(3'd4, 4'd7, 4'd7, 4'd7);
    @(negedge sysclk);
    push(3'd5, 4'd1, 4'd1, 4'd1);
    push(3'd0, 4'd1, 4'd1, 4'd1);
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL mrst_queued got %0d exp 2", fifo_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (Motor !== 6'd0 || fifo_count !== 4'd0 || seq_active !== 1'b0) begin errors++; $display("FAIL mrst_clear got motor=%h count=%0d active=%b exp 00/0/0", Motor, fifo_count, seq_active); end
    checks++; if (TValue0 !== 4'd0) begin errors++; $display("FAIL mrst_tvalue got %0d exp 0", TValue0); end
    @(negedge sysclk);
    rst = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge sysclk);
      if (Motor != 6'd0 || move_done) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mrst_lost got %0d exp 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    initFlag = 6'h3F;
    SS = 1'b0;
    Busy = 1'b0;
    cif.cmd_valid = 1'b0;
    drive(3'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_single();
    test_reject();
    test_zero();
    test_fill_drain();
    test_stop();
    test_uncal();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
